// File: rtl/led_breath_ctrl.sv
// Breathing-LED duty sequencer: triangular duty ramp with hold plateaus at
// both ends, updated once per PWM period and announced by a one-cycle strobe.
module led_breath_ctrl #(
  parameter int DUTY_W     = 8,
  parameter int STEP       = 1,
  parameter int HOLD_TICKS = 16,
  parameter int TICK_DIV   = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [DUTY_W-1:0] duty,
  output logic              duty_valid,
  output logic [1:0]        phase,
  output logic              cycle_done
);

  localparam int CNT_W  = $clog2(TICK_DIV);
  localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
  localparam logic [DUTY_W-1:0] MAX    = {DUTY_W{1'b1}};
  localparam logic [DUTY_W-1:0] STEP_V = DUTY_W'(STEP);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);

  typedef enum logic [1:0] {
    LOW_HOLD  = 2'd0,
    RAMP_UP   = 2'd1,
    HIGH_HOLD = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  // Top bit flags that the ramp hit its end (clamped at MAX / floored at 0).
  function automatic logic [DUTY_W:0] sat_up(input logic [DUTY_W-1:0] d);
    logic [DUTY_W:0] s;
    s = {1'b0, d} + {1'b0, STEP_V};
    if (s >= {1'b0, MAX}) sat_up = {1'b1, MAX};
    else                  sat_up = {1'b0, s[DUTY_W-1:0]};
  endfunction

  function automatic logic [DUTY_W:0] floor_down(input logic [DUTY_W-1:0] d);
    if (d <= STEP_V) floor_down = {1'b1, {DUTY_W{1'b0}}};
    else             floor_down = {1'b0, d - STEP_V};
  endfunction

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [HOLD_W-1:0] r_hold;
  logic [DUTY_W-1:0] r_duty;
  logic              r_valid;
  logic              r_done;

  logic              w_tick;
  logic              w_hold_end;
  logic [DUTY_W:0]   w_up;
  logic [DUTY_W:0]   w_dn;

  assign w_tick     = en && (r_cnt == CNT_LAST);
  assign w_hold_end = (r_hold == HOLD_LAST);
  assign w_up       = sat_up(r_duty);
  assign w_dn       = floor_down(r_duty);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= LOW_HOLD;
      r_cnt   <= '0;
      r_hold  <= '0;
      r_duty  <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_valid <= w_tick;
      r_done  <= 1'b0;
      // Disabling parks the divider at 0 so a full period elapses after re-enable.
      if (!en)         r_cnt <= '0;
      else if (w_tick) r_cnt <= '0;
      else             r_cnt <= r_cnt + 1'b1;

      if (w_tick) begin
        case (r_state)
          LOW_HOLD: begin
            if (w_hold_end) begin
              r_hold  <= '0;
              r_state <= RAMP_UP;
            end else begin
              r_hold <= r_hold + 1'b1;
            end
          end
          RAMP_UP: begin
            r_duty <= w_up[DUTY_W-1:0];
            if (w_up[DUTY_W]) r_state <= HIGH_HOLD;
          end
          HIGH_HOLD: begin
            if (w_hold_end) begin
              r_hold  <= '0;
              r_state <= RAMP_DOWN;
            end else begin
              r_hold <= r_hold + 1'b1;
            end
          end
          RAMP_DOWN: begin
            r_duty <= w_dn[DUTY_W-1:0];
            if (w_dn[DUTY_W]) begin
              r_state <= LOW_HOLD;
              r_done  <= 1'b1;
            end
          end
          default: r_state <= LOW_HOLD;
        endcase
      end
    end
  end

  assign duty       = r_duty;
  assign duty_valid = r_valid;
  assign phase      = r_state;
  assign cycle_done = r_done;

endmodule
